// File: rtl/lock_pkg.sv
// Shared constants and types for the keypad sequencer and its fail guard.
package lock_pkg;

  localparam int NUM_DIGITS = 6;

  localparam logic [3:0] KEY_CLR = 4'hA;
  localparam logic [3:0] KEY_ENT = 4'hB;

  localparam logic [1:0] ADDR_P0    = 2'b00;
  localparam logic [1:0] ADDR_P1    = 2'b01;
  localparam logic [1:0] ADDR_P2    = 2'b10;
  localparam logic [1:0] ADDR_JUDGE = 2'b11;

  typedef enum logic [2:0] {
    ST_COLLECT,
    ST_WRITE,
    ST_JUDGE,
    ST_RESULT,
    ST_LOCKOUT
  } state_e;

  function automatic logic is_digit(input logic [3:0] code);
    return code <= 4'd9;
  endfunction

endpackage

// File: rtl/lock_fail_guard.sv
// Consecutive verify-failure counter and lockout timer.
// tripped goes high once the count reaches MAX_FAIL; the guard then starts
// a LOCK_CYCLES-long lockout on the following edge and flags its last cycle
// with expire so the sequencer can leave LOCKOUT on the same edge.
module lock_fail_guard #(
  parameter int MAX_FAIL    = 3,
  parameter int LOCK_CYCLES = 16
) (
  input  logic clk,
  input  logic clr,
  input  logic inc,
  input  logic clr_cnt,
  output logic tripped,
  output logic expire,
  output logic locked
);

  localparam int FW = $clog2(MAX_FAIL + 1);
  localparam int TW = $clog2(LOCK_CYCLES + 1);

  logic [FW-1:0] fail_cnt_q, fail_cnt_d;
  logic [TW-1:0] timer_q, timer_d;
  logic          locked_q, locked_d;

  assign tripped = (fail_cnt_q >= FW'(MAX_FAIL));
  assign expire  = locked_q && (timer_q == '0);
  assign locked  = locked_q;

  // Next-state: run the lockout timer, otherwise track the failure count.
  always_comb begin
    fail_cnt_d = fail_cnt_q;
    timer_d    = timer_q;
    locked_d   = locked_q;
    if (locked_q) begin
      if (timer_q == '0) begin
        locked_d   = 1'b0;
        fail_cnt_d = '0;
      end else begin
        timer_d = timer_q - 1'b1;
      end
    end else if (tripped) begin
      locked_d = 1'b1;
      timer_d  = TW'(LOCK_CYCLES - 1);
    end else if (clr_cnt) begin
      fail_cnt_d = '0;
    end else if (inc) begin
      fail_cnt_d = fail_cnt_q + 1'b1;
    end
  end

  // State registers with synchronous clear.
  always_ff @(posedge clk) begin
    if (clr) begin
      fail_cnt_q <= '0;
      timer_q    <= '0;
      locked_q   <= 1'b0;
    end else begin
      fail_cnt_q <= fail_cnt_d;
      timer_q    <= timer_d;
      locked_q   <= locked_d;
    end
  end

endmodule

// File: rtl/lock_keypad_sequencer.sv
// Keypad front end for the six-digit lock controller: collects digits,
// writes them out as address-tagged pairs, runs the judge window and
// reports set/pass/fail, with lockout after repeated verify failures.
module lock_keypad_sequencer
  import lock_pkg::*;
#(
  parameter int WR_HOLD     = 2,
  parameter int JUDGE_LAT   = 2,
  parameter int MAX_FAIL    = 3,
  parameter int LOCK_CYCLES = 16
) (
  input  logic       clk,
  input  logic       clr,
  input  logic       key_vld,
  input  logic [3:0] key_code,
  input  logic       mode_in,
  input  logic       res,
  output logic [3:0] inA,
  output logic [3:0] inB,
  output logic       a0,
  output logic       a1,
  output logic       m,
  output logic       busy,
  output logic [2:0] entry_cnt,
  output logic       err,
  output logic       set_done,
  output logic       pass,
  output logic       fail,
  output logic       locked
);

  localparam int HOLD_MAX = (WR_HOLD > JUDGE_LAT) ? WR_HOLD : JUDGE_LAT;
  localparam int CW       = $clog2(HOLD_MAX + 1);

  state_e        state_q, state_d;
  logic [CW-1:0] phase_q, phase_d;
  logic [1:0]    pair_q, pair_d;
  logic [3:0]    digits_q [NUM_DIGITS];
  logic [3:0]    digits_d [NUM_DIGITS];
  logic [2:0]    entry_cnt_q, entry_cnt_d;
  logic [3:0]    in_a_q, in_a_d;
  logic [3:0]    in_b_q, in_b_d;
  logic [1:0]    addr_q, addr_d;
  logic          m_q, m_d;
  logic          busy_q, busy_d;
  logic          err_q, err_d;
  logic          set_done_q, set_done_d;
  logic          pass_q, pass_d;
  logic          fail_q, fail_d;

  logic          tripped;
  logic          expire;

  lock_fail_guard #(
    .MAX_FAIL    (MAX_FAIL),
    .LOCK_CYCLES (LOCK_CYCLES)
  ) u_fail_guard (
    .clk     (clk),
    .clr     (clr),
    .inc     (fail_d),
    .clr_cnt (pass_d),
    .tripped (tripped),
    .expire  (expire),
    .locked  (locked)
  );

  // Next-state and registered-output logic; outputs follow the next state
  // so they line up with the state they belong to.
  // NOTE: every variable gets a default at the top of the block, so no
  // path leaves one unassigned and no latch is inferred.
  always_comb begin
    state_d     = state_q;
    phase_d     = phase_q;
    pair_d      = pair_q;
    digits_d    = digits_q;
    entry_cnt_d = entry_cnt_q;
    in_a_d      = in_a_q;
    in_b_d      = in_b_q;
    addr_d      = ADDR_JUDGE;
    m_d         = m_q;
    busy_d      = 1'b0;
    err_d       = 1'b0;
    set_done_d  = 1'b0;
    pass_d      = 1'b0;
    fail_d      = 1'b0;

    unique case (state_q)
      ST_COLLECT: begin
        if (key_vld) begin
          if (is_digit(key_code)) begin
            if (entry_cnt_q < 3'(NUM_DIGITS)) begin
              digits_d[entry_cnt_q] = key_code;
              entry_cnt_d           = entry_cnt_q + 1'b1;
            end
          end else if (key_code == KEY_CLR) begin
            entry_cnt_d = '0;
          end else if (key_code == KEY_ENT) begin
            if (entry_cnt_q == 3'(NUM_DIGITS)) begin
              m_d     = mode_in;
              state_d = ST_WRITE;
              phase_d = '0;
              pair_d  = 2'd0;
            end else begin
              err_d       = 1'b1;
              entry_cnt_d = '0;
            end
          end
        end
      end
      ST_WRITE: begin
        if (phase_q == CW'(WR_HOLD - 1)) begin
          phase_d = '0;
          if (pair_q == 2'd2) begin
            state_d = ST_JUDGE;
          end else begin
            pair_d = pair_q + 1'b1;
          end
        end else begin
          phase_d = phase_q + 1'b1;
        end
      end
      ST_JUDGE: begin
        if (phase_q == CW'(JUDGE_LAT - 1)) begin
          phase_d     = '0;
          state_d     = ST_RESULT;
          entry_cnt_d = '0;
          if (m_q) begin
            pass_d = res;
            fail_d = !res;
          end else begin
            set_done_d = 1'b1;
          end
        end else begin
          phase_d = phase_q + 1'b1;
        end
      end
      ST_RESULT: begin
        state_d = tripped ? ST_LOCKOUT : ST_COLLECT;
      end
      ST_LOCKOUT: begin
        if (expire) begin
          state_d = ST_COLLECT;
        end
      end
      default: begin
        state_d = ST_COLLECT;
      end
    endcase

    busy_d = (state_d inside {ST_WRITE, ST_JUDGE, ST_LOCKOUT});

    if (state_d == ST_WRITE) begin
      unique case (pair_d)
        2'd0: begin
          addr_d = ADDR_P0;
          in_a_d = digits_q[0];
          in_b_d = digits_q[1];
        end
        2'd1: begin
          addr_d = ADDR_P1;
          in_a_d = digits_q[2];
          in_b_d = digits_q[3];
        end
        default: begin
          addr_d = ADDR_P2;
          in_a_d = digits_q[4];
          in_b_d = digits_q[5];
        end
      endcase
    end
  end

  // Control state and registered outputs with synchronous clear.
  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples its pre-edge value regardless of statement order.
  always_ff @(posedge clk) begin
    if (clr) begin
      state_q     <= ST_COLLECT;
      phase_q     <= '0;
      pair_q      <= 2'd0;
      entry_cnt_q <= '0;
      in_a_q      <= '0;
      in_b_q      <= '0;
      addr_q      <= ADDR_JUDGE;
      m_q         <= 1'b0;
      busy_q      <= 1'b0;
      err_q       <= 1'b0;
      set_done_q  <= 1'b0;
      pass_q      <= 1'b0;
      fail_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      phase_q     <= phase_d;
      pair_q      <= pair_d;
      entry_cnt_q <= entry_cnt_d;
      in_a_q      <= in_a_d;
      in_b_q      <= in_b_d;
      addr_q      <= addr_d;
      m_q         <= m_d;
      busy_q      <= busy_d;
      err_q       <= err_d;
      set_done_q  <= set_done_d;
      pass_q      <= pass_d;
      fail_q      <= fail_d;
    end
  end

  // Digit buffer.
  // NOTE: the buffer is not reset; a slot is only read after it has been
  // written, because write-out requires six collected digits.
  always_ff @(posedge clk) begin
    digits_q <= digits_d;
  end

  assign inA       = in_a_q;
  assign inB       = in_b_q;
  assign a1        = addr_q[1];
  assign a0        = addr_q[0];
  assign m         = m_q;
  assign busy      = busy_q;
  assign entry_cnt = entry_cnt_q;
  assign err       = err_q;
  assign set_done  = set_done_q;
  assign pass      = pass_q;
  assign fail      = fail_q;

endmodule
